// File: rtl/icache_flush_ctrl.sv
// Instruction-cache flush controller: drains refills, enables the line sweep, acks completion.
// Optional performance counters are built only when ICACHE_FLUSH_PERF_EN is defined.
module icache_flush_ctrl #(
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 flush_req_i,
    input  logic                 miss_pending_i,
    input  logic                 flush_done_i,
    output logic                 busy_o,
    output logic                 flush_enable_o,
    output logic                 flush_ack_o,
    output logic                 refill_abort_o,
    output logic [CNT_WIDTH-1:0] flush_count_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o
);

    localparam int unsigned TMR_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAN = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // Timer saturates at LAST; abort is armed one count earlier so the registered pulse lands on LAST.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ARM  = TMR_W'(DRAIN_TIMEOUT - 2);

    logic [1:0]       state_q, state_d;
    logic             pending_q, pending_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             abort_q, abort_d;

    // State, pending flag, drain timer and abort flag registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            timer_q   <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            timer_q   <= timer_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic; requests in DRAIN are absorbed, in CLEAN/ACK they collapse into one pending flush
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        abort_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_d = ST_DRAIN;
                    timer_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!miss_pending_i) begin
                    state_d = ST_CLEAN;
                end else begin
                    if (timer_q != TMR_LAST) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    abort_d = (timer_q == TMR_ARM);
                end
            end
            ST_CLEAN: begin
                if (flush_req_i) begin
                    pending_d = 1'b1;
                end
                if (flush_done_i) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (pending_q || flush_req_i) begin
                    pending_d = 1'b0;
                    state_d   = ST_DRAIN;
                    timer_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o         = (state_q != ST_IDLE);
    assign flush_enable_o = (state_q == ST_CLEAN);
    assign flush_ack_o    = (state_q == ST_ACK);
    assign refill_abort_o = abort_q;

`ifdef ICACHE_FLUSH_PERF_EN
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state_q == ST_ACK) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
            if ((state_q != ST_IDLE) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign flush_count_o  = flush_cnt_q;
    assign stall_cycles_o = stall_cnt_q;
`else
    assign flush_count_o  = '0;
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_icache_flush_ctrl.sv
// Directed testbench for icache_flush_ctrl with a behavioural 256-line sweep stage model.
module tb_icache_flush_ctrl;

    localparam int unsigned CNT_WIDTH = 32;
`ifdef ICACHE_FLUSH_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic                 clk_i;
    logic                 rstn_i;
    logic                 flush_req_i;
    logic                 miss_pending_i;
    logic                 flush_done_i;
    logic                 busy_o;
    logic                 flush_enable_o;
    logic                 flush_ack_o;
    logic                 refill_abort_o;
    logic [CNT_WIDTH-1:0] flush_count_o;
    logic [CNT_WIDTH-1:0] stall_cycles_o;

    icache_flush_ctrl #(
        .DRAIN_TIMEOUT(64),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .flush_req_i   (flush_req_i),
        .miss_pending_i(miss_pending_i),
        .flush_done_i  (flush_done_i),
        .busy_o        (busy_o),
        .flush_enable_o(flush_enable_o),
        .flush_ack_o   (flush_ack_o),
        .refill_abort_o(refill_abort_o),
        .flush_count_o (flush_count_o),
        .stall_cycles_o(stall_cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Sweep stage: walks lines 0..255 while enabled, done on line 255; shares the reset
    logic [7:0] sweep_addr;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sweep_addr <= 8'd0;
        end else if (flush_enable_o) begin
            sweep_addr <= sweep_addr + 8'd1;
        end
    end
    assign flush_done_i = flush_enable_o && (sweep_addr == 8'hFF);

    int tests_run;
    int tests_failed;

    int busy_first, busy_last, busy_cnt;
    int en_first, en_last, en_cnt;
    int ack_first, ack_last, ack_cnt;
    int abort_first, abort_cnt;

    task automatic do_reset();
        rstn_i = 1'b0;
        flush_req_i = 1'b0;
        miss_pending_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    // Runs ncyc cycles from cycle 0; miss high in cycles 0..miss_len-1; requests at r0..r3 (-1 = none)
    task automatic run_scenario(input int ncyc, input int miss_len,
                                input int r0, input int r1, input int r2, input int r3);
        busy_first = -1; busy_last = -1; busy_cnt = 0;
        en_first = -1; en_last = -1; en_cnt = 0;
        ack_first = -1; ack_last = -1; ack_cnt = 0;
        abort_first = -1; abort_cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            flush_req_i = (c == r0) || (c == r1) || (c == r2) || (c == r3);
            miss_pending_i = (c < miss_len);
            @(negedge clk_i);
            if (busy_o) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (flush_enable_o) begin
                if (en_first < 0) en_first = c;
                en_last = c;
                en_cnt++;
            end
            if (flush_ack_o) begin
                if (ack_first < 0) ack_first = c;
                ack_last = c;
                ack_cnt++;
            end
            if (refill_abort_o) begin
                if (abort_first < 0) abort_first = c;
                abort_cnt++;
            end
            @(posedge clk_i);
            #1;
        end
        flush_req_i = 1'b0;
        miss_pending_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        flush_req_i = 1'b0;
        miss_pending_i = 1'b0;
        #1;
        tests_run++;
        if ({busy_o, flush_enable_o, flush_ack_o, refill_abort_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b required 0000",
                     {busy_o, flush_enable_o, flush_ack_o, refill_abort_o});
        end
        tests_run++;
        if (flush_count_o !== '0 || stall_cycles_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_counters: got %0d/%0d required 0/0", flush_count_o, stall_cycles_o);
        end
        do_reset();
    endtask

    task automatic test_single_flush();
        do_reset();
        run_scenario(262, 0, 0, -1, -1, -1);
        tests_run++;
        if (busy_first != 1 || busy_last != 258 || busy_cnt != 258) begin
            tests_failed++;
            $display("FAIL single_busy: got %0d..%0d n=%0d required 1..258 n=258", busy_first, busy_last, busy_cnt);
        end
        tests_run++;
        if (en_first != 2 || en_last != 257 || en_cnt != 256) begin
            tests_failed++;
            $display("FAIL single_enable: got %0d..%0d n=%0d required 2..257 n=256", en_first, en_last, en_cnt);
        end
        tests_run++;
        if (ack_first != 258 || ack_cnt != 1) begin
            tests_failed++;
            $display("FAIL single_ack: got cycle %0d n=%0d required cycle 258 n=1", ack_first, ack_cnt);
        end
        tests_run++;
        if (abort_cnt != 0) begin
            tests_failed++;
            $display("FAIL single_abort: got %0d pulses required 0", abort_cnt);
        end
        tests_run++;
        if (flush_count_o !== CNT_WIDTH'(PERF * 1)) begin
            tests_failed++;
            $display("FAIL single_flush_count: got %0d required %0d", flush_count_o, PERF * 1);
        end
        tests_run++;
        if (stall_cycles_o !== CNT_WIDTH'(PERF * 258)) begin
            tests_failed++;
            $display("FAIL single_stall_cycles: got %0d required %0d", stall_cycles_o, PERF * 258);
        end
    endtask

    task automatic test_drain_wait();
        do_reset();
        run_scenario(272, 10, 0, -1, -1, -1);
        tests_run++;
        if (en_first != 11 || en_cnt != 256) begin
            tests_failed++;
            $display("FAIL drain_clean_entry: got %0d n=%0d required 11 n=256", en_first, en_cnt);
        end
        tests_run++;
        if (ack_first != 267 || ack_cnt != 1) begin
            tests_failed++;
            $display("FAIL drain_ack: got cycle %0d n=%0d required cycle 267 n=1", ack_first, ack_cnt);
        end
        tests_run++;
        if (abort_cnt != 0) begin
            tests_failed++;
            $display("FAIL drain_no_abort: got %0d pulses required 0", abort_cnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_scenario(362, 100, 0, -1, -1, -1);
        tests_run++;
        if (abort_first != 64 || abort_cnt != 1) begin
            tests_failed++;
            $display("FAIL timeout_abort: got cycle %0d n=%0d required cycle 64 n=1", abort_first, abort_cnt);
        end
        tests_run++;
        if (en_first != 101 || en_cnt != 256) begin
            tests_failed++;
            $display("FAIL timeout_clean_entry: got %0d n=%0d required 101 n=256", en_first, en_cnt);
        end
        tests_run++;
        if (ack_first != 357 || ack_cnt != 1) begin
            tests_failed++;
            $display("FAIL timeout_ack: got cycle %0d n=%0d required cycle 357 n=1", ack_first, ack_cnt);
        end
    endtask

    task automatic test_coalesce();
        do_reset();
        run_scenario(522, 0, 0, 1, 100, 200);
        tests_run++;
        if (ack_cnt != 2 || ack_first != 258 || ack_last != 516) begin
            tests_failed++;
            $display("FAIL coalesce_acks: got n=%0d at %0d,%0d required n=2 at 258,516", ack_cnt, ack_first, ack_last);
        end
        tests_run++;
        if (busy_first != 1 || busy_last != 516 || busy_cnt != 516) begin
            tests_failed++;
            $display("FAIL coalesce_busy: got %0d..%0d n=%0d required 1..516 n=516", busy_first, busy_last, busy_cnt);
        end
        tests_run++;
        if (en_cnt != 512) begin
            tests_failed++;
            $display("FAIL coalesce_enable: got n=%0d required 512", en_cnt);
        end
        tests_run++;
        if (flush_count_o !== CNT_WIDTH'(PERF * 2) || stall_cycles_o !== CNT_WIDTH'(PERF * 516)) begin
            tests_failed++;
            $display("FAIL coalesce_counters: got %0d/%0d required %0d/%0d",
                     flush_count_o, stall_cycles_o, PERF * 2, PERF * 516);
        end
    endtask

    task automatic test_ack_merge();
        do_reset();
        run_scenario(522, 0, 0, 100, 258, -1);
        tests_run++;
        if (ack_cnt != 2 || ack_first != 258 || ack_last != 516) begin
            tests_failed++;
            $display("FAIL ack_merge_acks: got n=%0d at %0d,%0d required n=2 at 258,516", ack_cnt, ack_first, ack_last);
        end
        tests_run++;
        if (busy_cnt != 516 || busy_last != 516) begin
            tests_failed++;
            $display("FAIL ack_merge_busy: got last=%0d n=%0d required last=516 n=516", busy_last, busy_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        run_scenario(150, 0, 0, -1, -1, -1);
        tests_run++;
        if (flush_enable_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_in_clean: got enable %b required 1", flush_enable_o);
        end
        rstn_i = 1'b0;
        #1;
        tests_run++;
        if ({busy_o, flush_enable_o, flush_ack_o, refill_abort_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_flags: got %b required 0000",
                     {busy_o, flush_enable_o, flush_ack_o, refill_abort_o});
        end
        tests_run++;
        if (flush_count_o !== '0 || stall_cycles_o !== '0) begin
            tests_failed++;
            $display("FAIL midreset_counters: got %0d/%0d required 0/0", flush_count_o, stall_cycles_o);
        end
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        run_scenario(262, 0, 0, -1, -1, -1);
        tests_run++;
        if (ack_first != 258 || ack_cnt != 1 || busy_cnt != 258 || en_cnt != 256) begin
            tests_failed++;
            $display("FAIL midreset_reflush: got ack %0d n=%0d busy n=%0d en n=%0d required 258 1 258 256",
                     ack_first, ack_cnt, busy_cnt, en_cnt);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_flush();
        test_drain_wait();
        test_timeout();
        test_coalesce();
        test_ack_merge();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/icache_flush_ctrl.md
# icache_flush_ctrl

Instruction-cache flush controller sitting directly upstream of the icache line-sweep (cleaning) stage. It accepts flush requests from the pipeline (fence.i, CSR-triggered invalidate), drains any in-flight refill, and holds the sweep stage's enable until that stage reports completion. It stalls fetch for the whole operation and returns a one-cycle acknowledge. Requests arriving during a flush are coalesced or queued as defined below.

## Interface
Parameters:
- DRAIN_TIMEOUT, 64: cycles spent waiting in DRAIN before `refill_abort_o` pulses; legal range 2..65535.
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- flush_req_i  in  1  flush request; sampled every cycle; one flush per sampled-high cycle, subject to coalescing.
- miss_pending_i  in  1  refill unit has a line fill in flight.
- flush_done_i  in  1  from the sweep stage; high in the cycle its line address equals 255.
- busy_o  out  1  fetch stall; high in every state except IDLE.
- flush_enable_o  out  1  to the sweep stage; high only in CLEAN.
- flush_ack_o  out  1  one-cycle completion pulse; high only in ACK.
- refill_abort_o  out  1  one-cycle pulse requesting the refill unit to abandon its fill.
- flush_count_o  out  CNT_WIDTH  completed flushes.
- stall_cycles_o  out  CNT_WIDTH  cycles with busy_o high.

## Operation
- FSM states: IDLE, DRAIN, CLEAN, ACK. All outputs are Moore outputs decoded from registered state, except the abort pulse, which is a registered flag.
- IDLE: when flush_req_i=1, go to DRAIN and clear the drain timer.
- DRAIN:
  - When miss_pending_i=0, go to CLEAN.
  - Otherwise increment the drain timer. When the timer equals DRAIN_TIMEOUT-1, pulse refill_abort_o for exactly one cycle.
  - After the abort pulse, stay in DRAIN until miss_pending_i=0. The timer saturates and there is no second abort within the same DRAIN visit.
- CLEAN: hold flush_enable_o=1 continuously. When flush_done_i=1, go to ACK.
- ACK: flush_ack_o=1. If the pending flag is set, clear it and go to DRAIN (timer cleared). Otherwise go to IDLE.
- Coalescing and queueing:
  - flush_req_i=1 while in DRAIN is absorbed, because the sweep has not yet started.
  - flush_req_i=1 while in CLEAN or ACK sets the pending flag. The flag is one bit deep, so any number of such requests collapses into one queued flush.
  - In ACK, a flush_req_i in the same cycle as the pending flag being set or read still yields exactly one queued flush.
- flush_done_i outside CLEAN is ignored. miss_pending_i outside DRAIN is ignored.
- Reset (asserted at any time, including mid-sweep):
  - state=IDLE, pending=0, timer=0, counters=0.
  - All outputs are 0: busy_o, flush_enable_o, flush_ack_o, refill_abort_o, flush_count_o, stall_cycles_o.
  - The sweep stage shares rstn_i, so it restarts from address 0.

## Timing
- Request high in cycle 0 with miss_pending_i=0:
  - DRAIN in cycle 1.
  - CLEAN in cycles 2..257 (sweep address 0..255, flush_done_i high in cycle 257).
  - ACK in cycle 258.
  - IDLE in cycle 259.
- busy_o is high for cycles 1..258 (258 cycles). flush_enable_o is high for exactly 256 cycles.
- Every cycle spent with miss_pending_i=1 in DRAIN adds one cycle to the latency.
- Back-to-back queued flush: ACK goes directly to DRAIN, so busy_o stays high with no IDLE gap.
- The counters update on the same edge as the state transition. Reads therefore lag by one cycle.

## Configuration
- Macro: ICACHE_FLUSH_PERF_EN.
- Defined:
  - flush_count_o increments by 1 on each cycle in ACK.
  - stall_cycles_o increments by 1 on each cycle with busy_o=1.
  - Both counters saturate at all-ones and never wrap.
- Undefined: both ports remain and are tied to 0. No counter flops are instantiated.

## Test plan
- Single flush, no miss: pulse flush_req_i in cycle 0.
  - Required: busy_o high in cycles 1..258; flush_enable_o high in 2..257; flush_ack_o high only in cycle 258; counters read 1 and 258.
- Drain wait: miss_pending_i high in cycles 0..9, request in cycle 0.
  - Required: CLEAN entered in cycle 11; ack in cycle 267; refill_abort_o never asserted (DRAIN_TIMEOUT=64).
- Timeout: miss_pending_i held high for 100 cycles.
  - Required: refill_abort_o high for exactly one cycle, in cycle 64; no second pulse; CLEAN entered once miss_pending_i drops.
- Coalesce/queue: request in cycle 0, again in cycle 1 (DRAIN), and again in cycles 100 and 200 (CLEAN).
  - Required: exactly two acks, in cycles 258 and 516; busy_o never low between them.
- Reset mid-sweep: assert rstn_i low asynchronously in cycle 150.
  - Required: all outputs are 0 immediately.
  - After release, a new request again takes 258 cycles to ack.
- With ICACHE_FLUSH_PERF_EN undefined, rerun the single-flush scenario.
  - Required: flush_count_o and stall_cycles_o stay 0.
